// File: rtl/branch_rs_pkg.sv
// Shared types for the branch reservation station and its oldest-ready select logic.
package branch_rs_pkg;

    localparam int BR_RS_DEPTH = 4;
    localparam int PHYS_REG_W  = 6;
    localparam int BR_MASK_W   = 4;

    typedef logic [PHYS_REG_W-1:0] PHYS_REG_IDX;
    typedef logic [BR_MASK_W-1:0]  BR_MASK;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        CLEAR   = 2'd1,
        SQUASH  = 2'd2
    } BR_TASK;

    typedef struct packed {
        logic [31:0] pc;
        PHYS_REG_IDX t1;
        PHYS_REG_IDX t2;
        logic        t1_ready;
        logic        t2_ready;
        BR_MASK      b_id;
        BR_MASK      b_mask;
    } RS_PACKET;

    // CLEAR mask update is applied before CDB wakeup for any packet in flight.
    function automatic RS_PACKET clear_and_wake(input RS_PACKET    p,
                                                input BR_TASK      br_task,
                                                input BR_MASK      br_id,
                                                input logic        cdb_valid,
                                                input PHYS_REG_IDX cdb_tag);
        RS_PACKET r;
        r = p;
        if (br_task == CLEAR && (r.b_mask & br_id) != '0)
            r.b_mask = r.b_mask ^ br_id;
        if (cdb_valid && r.t1 == cdb_tag)
            r.t1_ready = 1'b1;
        if (cdb_valid && r.t2 == cdb_tag)
            r.t2_ready = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/age_select.sv
// Combinational oldest-ready picker: grants the candidate with no older candidate
// according to a row-per-entry age matrix (row i, bit j set => j older than i).
module age_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]       cand,
    input  logic [DEPTH*DEPTH-1:0] age,
    output logic [DEPTH-1:0]       grant,
    output logic                   valid
);

    // The first-found guard keeps the grant one-hot even if the matrix were inconsistent.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand[i] && !valid && ((age[i*DEPTH +: DEPTH] & cand) == '0)) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station: holds dispatched branches until both source tags are
// ready, then issues the oldest ready one into a registered issue slot.
module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int DEPTH = BR_RS_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    input  RS_PACKET       in_pack,
    input  logic           cdb_valid,
    input  PHYS_REG_IDX    cdb_tag,
    input  logic           fu_ready,
    input  BR_TASK         rem_br_task,
    input  BR_MASK         rem_b_id,
    output logic           full,
    output logic [IDX_W:0] free_count,
    output logic           issue_valid,
    output RS_PACKET       issue_pack
);

    logic [DEPTH-1:0]            valid;
    RS_PACKET                    entry [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] age;

    RS_PACKET         upd [DEPTH];
    RS_PACKET         in_upd;
    logic [DEPTH-1:0] squash_hit;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] keep;
    logic             sel_valid;
    logic             in_squash;
    logic             do_insert;
    logic [IDX_W-1:0] ins_idx;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   used;

    always_comb begin
        used = '0;
        for (int i = 0; i < DEPTH; i++)
            used = used + {{IDX_W{1'b0}}, valid[i]};
    end

    assign free_count = (IDX_W+1)'(DEPTH) - used;
    assign full       = (free_count == '0);

    // The resolving branch itself survives a squash of its own id.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            squash_hit[i] = valid[i] && (rem_br_task == SQUASH)
                            && ((entry[i].b_mask & rem_b_id) != '0)
                            && (entry[i].b_id != rem_b_id);
            cand[i]       = valid[i] && entry[i].t1_ready && entry[i].t2_ready
                            && !squash_hit[i] && fu_ready;
            upd[i]        = clear_and_wake(entry[i], rem_br_task, rem_b_id, cdb_valid, cdb_tag);
        end
    end

    age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .cand  (cand),
        .age   (age),
        .grant (grant),
        .valid (sel_valid)
    );

    // Insert slot comes from pre-edge occupancy, so an issuing entry never frees it early.
    always_comb begin
        grant_idx = '0;
        ins_idx   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (grant[i])
                grant_idx = IDX_W'(i);
            if (!valid[i])
                ins_idx = IDX_W'(i);
        end
        keep      = valid & ~squash_hit & ~grant;
        in_squash = (rem_br_task == SQUASH) && ((in_pack.b_mask & rem_b_id) != '0);
        do_insert = in_valid && !full && !in_squash;
        in_upd    = clear_and_wake(in_pack, rem_br_task, rem_b_id, cdb_valid, cdb_tag);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid       <= '0;
            age         <= '0;
            issue_valid <= 1'b0;
            issue_pack  <= '0;
            for (int i = 0; i < DEPTH; i++)
                entry[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= upd[i];
                valid[i] <= keep[i];
                age[i]   <= age[i] & keep;
            end
            if (do_insert) begin
                entry[ins_idx] <= in_upd;
                valid[ins_idx] <= 1'b1;
                age[ins_idx]   <= keep;
            end
            issue_valid <= sel_valid;
            issue_pack  <= sel_valid ? upd[grant_idx] : '0;
        end
    end

endmodule

// File: tb/tb_branch_rs.sv
// Directed self-checking bench for branch_rs with hand-computed expectations.
module tb_branch_rs;
    import branch_rs_pkg::*;

    logic        clock;
    logic        reset;
    logic        in_valid;
    RS_PACKET    in_pack;
    logic        cdb_valid;
    PHYS_REG_IDX cdb_tag;
    logic        fu_ready;
    BR_TASK      rem_br_task;
    BR_MASK      rem_b_id;
    logic        full;
    logic [2:0]  free_count;
    logic        issue_valid;
    RS_PACKET    issue_pack;

    int n_compared   = 0;
    int n_mismatched = 0;

    localparam RS_PACKET NONE = '0;

    branch_rs dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_pack     (in_pack),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .fu_ready    (fu_ready),
        .rem_br_task (rem_br_task),
        .rem_b_id    (rem_b_id),
        .full        (full),
        .free_count  (free_count),
        .issue_valid (issue_valid),
        .issue_pack  (issue_pack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic RS_PACKET mk(input logic [31:0] pc, input int t1, input int t2,
                                    input logic r1, input logic r2,
                                    input BR_MASK bid, input BR_MASK bmask);
        RS_PACKET p;
        p.pc       = pc;
        p.t1       = PHYS_REG_IDX'(t1);
        p.t2       = PHYS_REG_IDX'(t2);
        p.t1_ready = r1;
        p.t2_ready = r2;
        p.b_id     = bid;
        p.b_mask   = bmask;
        return p;
    endfunction

    task automatic applyStimulus(input logic iv, input RS_PACKET ip, input logic cv,
                                 input int ct, input logic fr, input BR_TASK bt,
                                 input BR_MASK bid);
        in_valid    = iv;
        in_pack     = ip;
        cdb_valid   = cv;
        cdb_tag     = PHYS_REG_IDX'(ct);
        fu_ready    = fr;
        rem_br_task = bt;
        rem_b_id    = bid;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    task automatic checkState(input string name, input logic exp_valid,
                              input RS_PACKET exp_pack, input int exp_free);
        checkOutput({name, ".issue_valid"}, 64'(issue_valid), 64'(exp_valid));
        checkOutput({name, ".issue_pack"},  64'(issue_pack),  64'(exp_pack));
        checkOutput({name, ".free_count"},  64'(free_count),  64'(exp_free));
        checkOutput({name, ".full"},        64'(full),        64'(exp_free == 0));
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("reset", 0, NONE, 4);
        reset = 1'b1;
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("idle", 0, NONE, 4);

        $display("[TB] ordering: younger ready branch bypasses older waiting one");
        applyStimulus(1, mk(32'h100, 5, 6, 0, 1, 4'b0001, 4'b0000), 0, 0, 1, NOTHING, 4'b0000);
        checkState("ord.insA", 0, NONE, 3);
        applyStimulus(1, mk(32'h104, 1, 2, 1, 1, 4'b0010, 4'b0000), 0, 0, 1, NOTHING, 4'b0000);
        checkState("ord.insB", 0, NONE, 2);
        applyStimulus(0, NONE, 1, 5, 1, NOTHING, 4'b0000);
        checkState("ord.issB", 1, mk(32'h104, 1, 2, 1, 1, 4'b0010, 4'b0000), 3);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("ord.issA", 1, mk(32'h100, 5, 6, 1, 1, 4'b0001, 4'b0000), 4);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("ord.drain", 0, NONE, 4);

        $display("[TB] oldest-first with older entry in a higher slot");
        applyStimulus(1, mk(32'h300, 9, 9, 0, 0, 4'b0001, 4'b1000), 0, 0, 1, NOTHING, 4'b0000);
        checkState("age.insX", 0, NONE, 3);
        applyStimulus(1, mk(32'h200, 7, 3, 0, 1, 4'b0010, 4'b0000), 0, 0, 1, NOTHING, 4'b0000);
        checkState("age.insC", 0, NONE, 2);
        applyStimulus(0, NONE, 0, 0, 1, SQUASH, 4'b1000);
        checkState("age.sqX", 0, NONE, 3);
        applyStimulus(1, mk(32'h204, 2, 7, 1, 0, 4'b0100, 4'b0000), 0, 0, 1, NOTHING, 4'b0000);
        checkState("age.insD", 0, NONE, 2);
        applyStimulus(0, NONE, 1, 7, 1, NOTHING, 4'b0000);
        checkState("age.wake", 0, NONE, 2);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("age.issC", 1, mk(32'h200, 7, 3, 1, 1, 4'b0010, 4'b0000), 3);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("age.issD", 1, mk(32'h204, 2, 7, 1, 1, 4'b0100, 4'b0000), 4);

        $display("[TB] full and back-pressure");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, mk(32'h600 + 32'(4*i), 1, 2, 1, 1, 4'b0001, 4'b0000),
                          0, 0, 0, NOTHING, 4'b0000);
            checkState($sformatf("full.ins%0d", i), 0, NONE, 3 - i);
        end
        applyStimulus(1, mk(32'h610, 1, 2, 1, 1, 4'b0001, 4'b0000), 0, 0, 0, NOTHING, 4'b0000);
        checkState("full.drop", 0, NONE, 0);
        applyStimulus(1, mk(32'h614, 1, 2, 1, 1, 4'b0001, 4'b0000), 0, 0, 1, NOTHING, 4'b0000);
        checkState("full.iss0", 1, mk(32'h600, 1, 2, 1, 1, 4'b0001, 4'b0000), 1);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("full.iss1", 1, mk(32'h604, 1, 2, 1, 1, 4'b0001, 4'b0000), 2);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("full.iss2", 1, mk(32'h608, 1, 2, 1, 1, 4'b0001, 4'b0000), 3);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("full.iss3", 1, mk(32'h60C, 1, 2, 1, 1, 4'b0001, 4'b0000), 4);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("full.empty", 0, NONE, 4);

        $display("[TB] squash");
        applyStimulus(1, mk(32'h400, 11, 12, 0, 0, 4'b0001, 4'b0010), 0, 0, 1, NOTHING, 4'b0000);
        checkState("sq.insQ1", 0, NONE, 3);
        applyStimulus(1, mk(32'h404, 11, 12, 0, 0, 4'b1000, 4'b0100), 0, 0, 1, NOTHING, 4'b0000);
        checkState("sq.insQ2", 0, NONE, 2);
        applyStimulus(1, mk(32'h408, 1, 2, 1, 1, 4'b1000, 4'b0010), 0, 0, 1, SQUASH, 4'b0010);
        checkState("sq.kill", 0, NONE, 3);
        applyStimulus(0, NONE, 1, 11, 1, NOTHING, 4'b0000);
        checkState("sq.dropped", 0, NONE, 3);
        applyStimulus(0, NONE, 1, 12, 1, NOTHING, 4'b0000);
        checkState("sq.wake", 0, NONE, 3);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("sq.issQ2", 1, mk(32'h404, 11, 12, 1, 1, 4'b1000, 4'b0100), 4);
        applyStimulus(1, mk(32'h40C, 1, 2, 1, 1, 4'b0100, 4'b0010), 0, 0, 1, NOTHING, 4'b0000);
        checkState("sq.insR", 0, NONE, 3);
        applyStimulus(0, NONE, 0, 0, 1, SQUASH, 4'b0010);
        checkState("sq.noIssue", 0, NONE, 4);

        $display("[TB] clear");
        applyStimulus(1, mk(32'h500, 13, 14, 0, 1, 4'b0001, 4'b0110), 0, 0, 1, NOTHING, 4'b0000);
        checkState("clr.insW", 0, NONE, 3);
        applyStimulus(1, mk(32'h504, 20, 21, 1, 1, 4'b1000, 4'b0110), 0, 0, 1, NOTHING, 4'b0000);
        checkState("clr.insV", 0, NONE, 2);
        applyStimulus(1, mk(32'h508, 15, 16, 0, 1, 4'b0010, 4'b0100), 1, 13, 1, CLEAR, 4'b0100);
        checkState("clr.issV", 1, mk(32'h504, 20, 21, 1, 1, 4'b1000, 4'b0010), 2);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("clr.issW", 1, mk(32'h500, 13, 14, 1, 1, 4'b0001, 4'b0010), 3);
        applyStimulus(0, NONE, 1, 15, 1, NOTHING, 4'b0000);
        checkState("clr.wakeY", 0, NONE, 3);
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("clr.issY", 1, mk(32'h508, 15, 16, 1, 1, 4'b0010, 4'b0000), 4);

        $display("[TB] reset mid-operation");
        applyStimulus(1, mk(32'h700, 1, 2, 1, 1, 4'b0001, 4'b0000), 0, 0, 1, NOTHING, 4'b0000);
        checkState("rst.insZ", 0, NONE, 3);
        reset = 1'b0;
        applyStimulus(1, mk(32'h704, 1, 2, 1, 1, 4'b0001, 4'b0000), 0, 0, 1, NOTHING, 4'b0000);
        checkState("rst.hit", 0, NONE, 4);
        reset = 1'b1;
        applyStimulus(0, NONE, 0, 0, 1, NOTHING, 4'b0000);
        checkState("rst.after", 0, NONE, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/branch_rs.md
Name: branch_rs

Overview:
- Dedicated reservation station for conditional branches, directly upstream of the branch functional unit.
- Buffers dispatched branch RS_PACKETs until both source tags are ready.
- Wakes entries from the CDB and issues the oldest ready branch into a one-entry output register. The issue/regfile-read stage turns that register into the FU's ISSUE_PACKET and rd_en.
- Applies branch-resolution CLEAR and SQUASH broadcasts to every buffered entry and to the output register.

Parameters:
- DEPTH, 4, number of branch RS entries (power of 2, ≥2).
- IDX_W, $clog2(DEPTH), entry index width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clock)
- in_valid  in  1  dispatch writes a branch this cycle
- in_pack  in  RS_PACKET  dispatched branch; includes t1/t2 tags, t1_ready/t2_ready, b_id, b_mask
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  PHYS_REG_IDX  CDB broadcast tag
- fu_ready  in  1  downstream issue slot can accept a packet this cycle
- rem_br_task  in  BR_TASK  NOTHING / CLEAR / SQUASH from resolving branch
- rem_b_id  in  BR_MASK  one-hot id of resolving branch
- full  out  1  no free entry (registered-state based)
- free_count  out  IDX_W+1  number of free entries
- issue_valid  out  1  issue_pack valid (registered)
- issue_pack  out  RS_PACKET  issued branch (registered)

Behaviour:
- Reset (reset==0 at posedge):
  - All entries invalid; age matrix cleared.
  - issue_valid=0, issue_pack='0, full=0, free_count=DEPTH.
  - Reset overrides every other input, including mid-operation.
- Entry state: valid, RS_PACKET, t1_ready, t2_ready. The age matrix row i marks which entries are older than i.
- Insert:
  - Occurs if in_valid && !full && !(rem_br_task==SQUASH && (in_pack.b_mask & rem_b_id)!=0).
  - Writes the lowest-index free entry and marks it younger than all currently valid entries.
  - in_valid while full: the packet is dropped silently. Dispatch must honour full.
  - full and free_count reflect pre-edge state. A same-cycle issue does not free a slot for a same-cycle insert.
- Wakeup:
  - cdb_valid && tag match sets t1_ready/t2_ready on every valid entry.
  - The incoming in_pack is also matched (bypass), so a same-cycle insert+broadcast enters ready.
  - Wakeup is registered: an entry woken at edge k is selectable in cycle k+1.
- Select:
  - Candidates are valid && t1_ready && t2_ready && not squashed this cycle.
  - The oldest candidate (no older valid candidate in the age matrix) is chosen when fu_ready==1.
  - At most one issue per cycle.
- Issue register:
  - On selection: issue_valid<=1 and issue_pack<=entry; the entry is invalidated and its age column cleared.
  - Otherwise issue_valid<=0 and issue_pack<='0.
  - Minimum latency: in_valid with ready operands at edge k gives issue_valid=1 after edge k+1.
- CLEAR (rem_br_task==CLEAR):
  - b_mask ^= rem_b_id on every valid entry whose b_mask has that bit, on the in_pack being inserted, and on the packet loaded into issue_pack.
  - Entries without the bit are unchanged.
- SQUASH (rem_br_task==SQUASH):
  - Invalidates every entry whose b_mask & rem_b_id != 0; these are excluded from select in the same cycle.
  - If the current issue_pack carries the bit, issue_valid<=0 and issue_pack<='0 next edge, unless a surviving entry issues.
  - An entry whose own b_id equals rem_b_id is not squashed.
- Simultaneous insert + issue + wakeup + CLEAR in one cycle are all legal and applied independently. The order for a single entry is: CLEAR mask update, then wakeup, then select.
- NOTHING: no mask effect.
- free_count = DEPTH − popcount(valid), updated each edge. full = (free_count==0).

Decomposition:
- Shared package / sys_defs.svh:
  - RS_PACKET, BR_MASK, BR_TASK (NOTHING/CLEAR/SQUASH), PHYS_REG_IDX.
  - Add BR_RS_DEPTH constant.
- Sub-module age_select: combinational oldest-ready picker. Inputs are DEPTH candidate bits and the DEPTH×DEPTH age matrix. Outputs are a one-hot grant and a valid bit. It is instantiated once and reusable by other RSes.

Test Plan:
- Reset + idle: hold reset=0 2 cycles → issue_valid=0, free_count=4, full=0. Release and insert nothing → outputs unchanged.
- Ordering: insert A (t1=5 not ready, t2 ready), then B (both ready). Next cycle B issues; cdb_tag=5 → A issues one cycle after wakeup.
- Oldest-first: insert A then B, both waiting on tag 7; cdb_tag=7 → A issues first, B the following cycle.
- Full/back-pressure: insert 4 with fu_ready=0 → full=1, free_count=0. A fifth in_valid is dropped. fu_ready=1 → oldest issues, free_count=1.
- SQUASH: entries with b_mask 4'b0010 and 4'b0100; rem_br_task=SQUASH, rem_b_id=4'b0010 → first invalidated, free_count+1. Insert with b_mask 4'b0010 that same cycle is dropped.
- CLEAR: entry b_mask 4'b0110; rem_br_task=CLEAR, rem_b_id=4'b0100 → b_mask becomes 4'b0010. Same-cycle issued packet shows 4'b0010 in issue_pack.
